// File: rtl/gain_table.sv
// Double-buffered per-channel gain store: the host fills the shadow bank while the
// requantizer reads the active bank; a commit swaps the banks at the next spectrum end.
module gain_table #(
  parameter int                NCHAN        = 2048,
  parameter int                ADDR_W       = 11,
  parameter int                GAIN_W       = 11,
  parameter logic [GAIN_W-1:0] DEFAULT_GAIN = 11'h400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic [GAIN_W-1:0] gain,
  input  logic              wr_start,
  input  logic              wr_en,
  input  logic [GAIN_W-1:0] wr_data,
  input  logic              commit,
  output logic              swap_pending,
  output logic              active_bank,
  output logic              loaded,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              wr_err
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t            state;
  logic [GAIN_W-1:0] bank [2][NCHAN];
  logic [ADDR_W:0]   ptr_base;
  logic              boundary, swap, wr_ok, wr_drop;

  // wr_start rebases the pointer in the same cycle, so a coincident write lands at 0
  assign ptr_base     = wr_start ? '0 : wr_ptr;
  assign boundary     = ce && (addr == ADDR_W'(NCHAN - 1));
  assign swap         = (state == PENDING) && boundary;
  assign wr_ok        = wr_en && (state == IDLE) && (ptr_base < (ADDR_W+1)'(NCHAN));
  assign wr_drop      = wr_en && !wr_ok;
  assign swap_pending = (state == PENDING);

  // Last channel of the swap spectrum still reads the old bank: active_bank flips on that edge
  assign gain = loaded ? bank[active_bank][addr] : DEFAULT_GAIN;

  always_ff @(posedge clk) begin
    if (wr_ok) bank[~active_bank][ptr_base[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      active_bank <= 1'b0;
      loaded      <= 1'b0;
      wr_ptr      <= '0;
      wr_err      <= 1'b0;
    end else begin
      if (swap)       wr_ptr <= '0;
      else if (wr_ok) wr_ptr <= ptr_base + (ADDR_W+1)'(1);
      else            wr_ptr <= ptr_base;

      // A drop in the same cycle as wr_start still leaves the error flagged
      if (wr_drop)       wr_err <= 1'b1;
      else if (wr_start) wr_err <= 1'b0;

      case (state)
        IDLE:    if (commit) state <= PENDING;
        PENDING: if (boundary) begin
          state       <= IDLE;
          active_bank <= ~active_bank;
          loaded      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gain_table.sv
// Scoreboard bench for gain_table: a table-level model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_gain_table;
  localparam int NCHAN = 2048;
  localparam int AW    = 11;
  localparam int GW    = 11;
  localparam logic [GW-1:0] DEF = 11'h400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [GW-1:0] gain;
  logic          wr_start = 1'b0, wr_en = 1'b0, commit = 1'b0;
  logic [GW-1:0] wr_data = '0;
  logic          swap_pending, active_bank, loaded, wr_err;
  logic [AW:0]   wr_ptr;

  gain_table dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .gain(gain),
    .wr_start(wr_start), .wr_en(wr_en), .wr_data(wr_data), .commit(commit),
    .swap_pending(swap_pending), .active_bank(active_bank), .loaded(loaded),
    .wr_ptr(wr_ptr), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [GW-1:0] gain;
    bit            ab, ld, pend, err;
    int            ptr;
  } exp_t;

  exp_t q[$];
  int   checks = 0, fails = 0;
  bit   chk_en = 1'b0;

  // Model: two whole tables, the live one and the one being loaded
  logic [GW-1:0] m_live [NCHAN];
  logic [GW-1:0] m_shad [NCHAN];
  bit m_ab = 0, m_ld = 0, m_pend = 0, m_err = 0;
  int m_ptr = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      if (fails <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_step(input bit c, input int a, input bit ws, input bit we,
                            input logic [GW-1:0] wd, input bit cm);
    logic [GW-1:0] t;
    bit do_swap;
    do_swap = m_pend && c && (a == NCHAN - 1);
    if (ws) begin m_ptr = 0; m_err = 0; end
    if (we) begin
      if (m_pend || m_ptr == NCHAN) m_err = 1;
      else begin m_shad[m_ptr] = wd; m_ptr++; end
    end
    if (do_swap) begin
      for (int i = 0; i < NCHAN; i++) begin t = m_live[i]; m_live[i] = m_shad[i]; m_shad[i] = t; end
      m_ab = !m_ab; m_ld = 1; m_ptr = 0; m_pend = 0;
    end else if (!m_pend && cm) m_pend = 1;
  endtask

  // Called just after a posedge: drive, predict, clock, advance the model
  task automatic cyc(input bit c, input int a, input bit ws, input bit we,
                     input logic [GW-1:0] wd, input bit cm);
    exp_t e;
    ce = c; addr = AW'(a); wr_start = ws; wr_en = we; wr_data = wd; commit = cm;
    e.gain = m_ld ? m_live[a] : DEF;
    e.ab = m_ab; e.ld = m_ld; e.pend = m_pend; e.err = m_err; e.ptr = m_ptr;
    q.push_back(e);
    @(posedge clk);
    model_step(c, a, ws, we, wd, cm);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, 0);
  endtask

  task automatic sweep(input bit stall);
    for (int a = 0; a < NCHAN; a++) begin
      if (stall && $urandom_range(3) == 0) cyc(0, a, 0, 0, '0, 0);
      cyc(1, a, 0, 0, '0, 0);
    end
  endtask

  task automatic load_rand(input int n, input bit commit_last);
    cyc(0, 0, 1, 0, '0, 0);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 1, GW'($urandom), commit_last && (i == n - 1));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() == 0) begin
        checks++; fails++;
        $display("FAIL scoreboard_empty at %0t: got no expectation, required one per cycle", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (!$isunknown(e.gain)) check("gain", int'(gain), int'(e.gain));
        check("active_bank", int'(active_bank), int'(e.ab));
        check("loaded", int'(loaded), int'(e.ld));
        check("swap_pending", int'(swap_pending), int'(e.pend));
        check("wr_err", int'(wr_err), int'(e.err));
        check("wr_ptr", int'(wr_ptr), e.ptr);
      end
    end
  end

  initial begin
    for (int i = 0; i < NCHAN; i++) begin m_live[i] = 'x; m_shad[i] = 'x; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // Unloaded: default gain on every address
    sweep(0);

    // Ramp table; first pass still default, swap on the last channel
    cyc(0, 0, 1, 0, '0, 0);
    for (int i = 0; i < NCHAN; i++) cyc(0, 0, 0, 1, GW'(i + 1), 0);
    cyc(0, 0, 0, 0, '0, 1);
    sweep(0);
    sweep(0);

    // Overfill: extra write dropped, then wr_start clears the error
    load_rand(NCHAN, 0);
    cyc(0, 0, 0, 1, 11'h7FF, 0);
    idle(1);
    cyc(0, 0, 1, 0, '0, 0);
    idle(1);

    // Commit with the requantizer stalled on the last channel: no swap until ce
    cyc(0, NCHAN - 1, 0, 0, '0, 1);
    for (int i = 0; i < 100; i++) cyc(0, NCHAN - 1, 0, 0, '0, 0);
    cyc(1, NCHAN - 1, 0, 0, '0, 0);
    idle(2);
    sweep(1);

    // Writes and a second commit while pending are rejected
    load_rand(NCHAN, 0);
    cyc(0, 0, 0, 0, '0, 1);
    cyc(0, 0, 0, 1, 11'h7FF, 0);
    cyc(0, 0, 0, 0, '0, 1);
    sweep(1);
    sweep(1);

    // Partial load with commit on the last write
    load_rand(10, 1);
    sweep(0);
    sweep(0);

    // Commit landing on a boundary waits for the following one
    load_rand(3, 0);
    cyc(1, NCHAN - 1, 0, 0, '0, 1);
    sweep(0);
    sweep(0);

    // Asynchronous reset in the middle of a pending swap
    load_rand(5, 0);
    cyc(0, 0, 0, 0, '0, 1);
    cyc(0, 0, 0, 1, 11'h7FF, 0);
    idle($urandom_range(1, 40));
    chk_en = 1'b0;
    addr = AW'($urandom_range(0, NCHAN - 1));
    #2 rst = 1'b0;
    #1;
    check("rst_gain", int'(gain), int'(DEF));
    check("rst_active_bank", int'(active_bank), 0);
    check("rst_loaded", int'(loaded), 0);
    check("rst_swap_pending", int'(swap_pending), 0);
    check("rst_wr_ptr", int'(wr_ptr), 0);
    check("rst_wr_err", int'(wr_err), 0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
